// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
// The master side is the requester/consumer; the slave side is the controller.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a_in, b_in, cin, out_ready,
    input  in_ready, out_valid, sum_out, cout, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, cin, out_ready,
    output in_ready, out_valid, sum_out, cout, busy
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell is reused for WIDTH
// cycles, LSB first. The carry lives in a single flop, and the sum is
// assembled by shifting cell outputs into the MSB of a shift register.

// One-bit full adder cell: x = sum, y = carry out.
module lab2_t2 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic x,
  output logic y
);
  assign x = a ^ b ^ c;
  assign y = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic [WIDTH-1:0] r_sum_out;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_x;
  logic             w_y;
  logic [WIDTH-1:0] w_s_next;

  // The only adder in the design: bit 0 of each operand plus the carry flop.
  lab2_t2 u_cell (
    .a (r_a_sr[0]),
    .b (r_b_sr[0]),
    .c (r_carry),
    .x (w_x),
    .y (w_y)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_s_w1
      assign w_s_next = w_x;
    end else begin : g_s_wn
      assign w_s_next = {w_x, r_s_sr[WIDTH-1:1]};
    end
  endgenerate

  // Control FSM with registered handshake outputs; reset beats any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_s_sr      <= '0;
      r_sum_out   <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a_sr     <= bus.a_in;
            r_b_sr     <= bus.b_in;
            r_carry    <= bus.cin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_s_sr  <= w_s_next;
          r_carry <= w_y;
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          if (r_cnt == LAST) begin
            r_sum_out   <= w_s_next;
            r_cout      <= w_y;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum_out   = r_sum_out;
  assign bus.cout      = r_cout;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances share clock and reset.
module tb_serial_add_ctrl;
  logic clk;
  logic rst;

  serial_add_ctrl_if #(.WIDTH(8)) if8 ();
  serial_add_ctrl_if #(.WIDTH(1)) if1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] last_s;
  logic       last_c;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    int         hold;
    bit         noise;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One WIDTH=8 transaction with latency, hold-value and backpressure checks.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input int hold, input bit noise,
                     input logic [7:0] es, input logic ec);
    int k;
    bit got;
    k = 0;
    while (!if8.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_idle", int'(if8.in_ready), 1);
    if8.in_valid = 1'b1;
    if8.a_in     = a;
    if8.b_in     = b;
    if8.cin      = ci;
    @(negedge clk);
    if (noise) begin
      if8.in_valid = 1'b1;
      if8.a_in     = 8'h11;
      if8.b_in     = 8'h22;
    end else begin
      if8.in_valid = 1'b0;
      if8.a_in     = 8'($urandom);
      if8.b_in     = 8'($urandom);
    end
    if8.cin = 1'($urandom);
    k   = 0;
    got = 1'b0;
    while (k <= 12) begin
      if (if8.out_valid) begin
        got = 1'b1;
        break;
      end
      chk("run_busy", int'(if8.busy), 1);
      chk("run_in_ready", int'(if8.in_ready), 0);
      chk("run_sum_held", int'(if8.sum_out), int'(last_s));
      chk("run_cout_held", int'(if8.cout), int'(last_c));
      @(negedge clk);
      k++;
    end
    if8.in_valid = 1'b0;
    chk("latency", k, 8);
    if (got) begin
      chk("sum_out", int'(if8.sum_out), int'(es));
      chk("cout", int'(if8.cout), int'(ec));
      chk("hold_busy", int'(if8.busy), 0);
      chk("hold_in_ready", int'(if8.in_ready), 0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("bp_out_valid", int'(if8.out_valid), 1);
        chk("bp_sum", int'(if8.sum_out), int'(es));
        chk("bp_cout", int'(if8.cout), int'(ec));
      end
      if8.out_ready = 1'b1;
      @(negedge clk);
      if8.out_ready = 1'b0;
      chk("post_out_valid", int'(if8.out_valid), 0);
      chk("post_in_ready", int'(if8.in_ready), 1);
      chk("post_sum_held", int'(if8.sum_out), int'(es));
    end
    last_s = es;
    last_c = ec;
  endtask

  logic [8:0] model;

  initial begin
    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0, 1'b0};
    tbl[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0, 1'b1};
    tbl[4] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 5, 1'b0};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1, 1'b1};
    tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 1'b0};
    tbl[7] = '{8'h55, 8'h33, 1'b1, 8'h89, 1'b0, 2, 1'b0};

    rst = 1'b1;
    if8.in_valid = 1'b0; if8.a_in = '0; if8.b_in = '0; if8.cin = 1'b0; if8.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.a_in = '0; if1.b_in = '0; if1.cin = 1'b0; if1.out_ready = 1'b0;
    last_s = 8'h00;
    last_c = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(if8.in_ready), 1);
    chk("rst_out_valid", int'(if8.out_valid), 0);
    chk("rst_busy", int'(if8.busy), 0);
    chk("rst_sum", int'(if8.sum_out), 0);
    chk("rst_cout", int'(if8.cout), 0);
    chk("rst1_in_ready", int'(if1.in_ready), 1);

    // Directed table
    for (int i = 0; i < 8; i++)
      op8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].hold, tbl[i].noise, tbl[i].s, tbl[i].c);

    // Reset in the middle of RUN discards the operation
    if8.in_valid = 1'b1; if8.a_in = 8'hFF; if8.b_in = 8'hFF; if8.cin = 1'b0;
    @(negedge clk);
    if8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun_busy", int'(if8.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_out_valid", int'(if8.out_valid), 0);
    chk("mrst_busy", int'(if8.busy), 0);
    chk("mrst_in_ready", int'(if8.in_ready), 1);
    chk("mrst_sum", int'(if8.sum_out), 0);
    chk("mrst_cout", int'(if8.cout), 0);
    repeat (10) @(negedge clk);
    chk("mrst_no_result", int'(if8.out_valid), 0);
    last_s = 8'h00;
    last_c = 1'b0;
    op8(8'h01, 8'h02, 1'b0, 0, 1'b0, 8'h03, 1'b0);

    // Randomized operations against plain arithmetic
    for (int r = 0; r < 25; r++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      op8(ra, rb, rc, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
          model[7:0], model[8]);
    end

    // WIDTH=1 sweep of every (a,b,cin)
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] exp1;
      v = 3'(i);
      exp1 = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
      if1.in_valid = 1'b1; if1.a_in = v[2]; if1.b_in = v[1]; if1.cin = v[0];
      @(negedge clk);
      if1.in_valid = 1'b0;
      chk("w1_not_ready", int'(if1.in_ready), 0);
      @(negedge clk);
      chk("w1_out_valid", int'(if1.out_valid), 1);
      chk("w1_result", int'({if1.cout, if1.sum_out}), int'(exp1));
      if1.out_ready = 1'b1;
      @(negedge clk);
      if1.out_ready = 1'b0;
      chk("w1_in_ready", int'(if1.in_ready), 1);
      chk("w1_out_valid_low", int'(if1.out_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
